// File: rtl/snake_renderer.sv
// snake_renderer: per-cell colour generator for the snake game display.
// Normal play draws the snake in green and the food in red on black.
// The game-over screen draws an animated grey level with a centred
// "GAME OVER" banner in the inverse grey.
// Pixel colour is combinational from the inputs and the gray level.
// The gray level is the only state in the block.

module snake_renderer #(
    parameter int GRID_W   = 100,
    parameter int GRID_H   = 75,
    parameter int MAX_LEN  = 64,
    parameter int POS_BITS = 13
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           frame_tick,
    input  logic [10:0]                    XCoord,
    input  logic [10:0]                    YCoord,
    input  logic [POS_BITS*MAX_LEN-1:0]    snake_body_flat,
    input  logic [$clog2(MAX_LEN+1)-1:0]   snake_length,
    input  logic [POS_BITS-1:0]            food_pos,
    input  logic                           game_over,
    output logic [3:0]                     pixel_red,
    output logic [3:0]                     pixel_green,
    output logic [3:0]                     pixel_blue
);

    // Banner geometry: nine 8x8 characters centred on the grid.
    localparam int TEXT_W = 72;
    localparam int TEXT_H = 8;
    localparam int X0     = (GRID_W - TEXT_W) / 2;
    localparam int Y0     = (GRID_H - TEXT_H) / 2;

    // Glyph bitmaps, row 0 in the top byte, MSB is the leftmost column.
    localparam logic [63:0] GLYPH_G = 64'h3C66_606E_6666_3C00;
    localparam logic [63:0] GLYPH_A = 64'h183C_6666_7E66_6600;
    localparam logic [63:0] GLYPH_M = 64'h6377_7F6B_6363_6300;
    localparam logic [63:0] GLYPH_E = 64'h7E60_607C_6060_7E00;
    localparam logic [63:0] GLYPH_O = 64'h3C66_6666_6666_3C00;
    localparam logic [63:0] GLYPH_V = 64'h6666_6666_663C_1800;
    localparam logic [63:0] GLYPH_R = 64'h7C66_667C_6C66_6600;

    // Bitmap for character slot ch of the "GAME OVER" string.
    function automatic logic [63:0] banner_glyph(input logic [3:0] ch);
        logic [63:0] g;
        case (ch)
            4'd0:    g = GLYPH_G;
            4'd1:    g = GLYPH_A;
            4'd2:    g = GLYPH_M;
            4'd3:    g = GLYPH_E;
            4'd4:    g = 64'h0000_0000_0000_0000;
            4'd5:    g = GLYPH_O;
            4'd6:    g = GLYPH_V;
            4'd7:    g = GLYPH_E;
            4'd8:    g = GLYPH_R;
            default: g = 64'h0000_0000_0000_0000;
        endcase
        return g;
    endfunction

    logic [3:0]          gray_r;
    logic [POS_BITS-1:0] pos_s;
    logic                in_grid_s;
    logic                snake_hit_s;
    logic                food_hit_s;
    logic                in_banner_s;
    logic [6:0]          banner_x_s;
    logic [2:0]          row_s;
    logic [2:0]          col_s;
    logic [3:0]          char_s;
    logic [63:0]         glyph_s;
    logic [7:0]          font_row_s;
    logic                font_bit_s;
    logic [3:0]          shade_s;

    // Gray level: advances once per frame during game over, cleared otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gray_r <= 4'd0;
        end else if (!game_over) begin
            gray_r <= 4'd0;
        end else if (frame_tick) begin
            gray_r <= gray_r + 4'd1;
        end else begin
            gray_r <= gray_r;
        end
    end

    // Linear cell position (modulo 2^POS_BITS) and grid bounds test.
    always_comb begin
        pos_s     = POS_BITS'(YCoord) * POS_BITS'(GRID_W) + POS_BITS'(XCoord);
        in_grid_s = (XCoord < 11'(GRID_W)) && (YCoord < 11'(GRID_H));
    end

    // Snake and food hit detection; only the first snake_length segments count.
    always_comb begin
        snake_hit_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            snake_hit_s = snake_hit_s |
                ((i < int'(snake_length)) &&
                 (snake_body_flat[i*POS_BITS +: POS_BITS] == pos_s));
        end
        food_hit_s = (pos_s == food_pos);
    end

    // Banner lookup: character slot, glyph row/column and the font bit.
    always_comb begin
        in_banner_s = (XCoord >= 11'(X0)) && (XCoord < 11'(X0 + TEXT_W)) &&
                      (YCoord >= 11'(Y0)) && (YCoord < 11'(Y0 + TEXT_H));
        banner_x_s  = 7'(XCoord - 11'(X0));
        row_s       = 3'(YCoord - 11'(Y0));
        char_s      = {1'b0, banner_x_s[6:4]} + {3'b000, 1'b0} +
                      {1'b0, 3'b000} + 4'(banner_x_s[6:3]) - 4'({1'b0, banner_x_s[6:4]});
        col_s       = banner_x_s[2:0];
        glyph_s     = banner_glyph(char_s);
        font_row_s  = glyph_s[{3'd7 - row_s, 3'b000} +: 8];
        font_bit_s  = font_row_s[3'd7 - col_s];
    end

    // Final colour selection; game over overrides snake and food entirely.
    always_comb begin
        pixel_red   = 4'h0;
        pixel_green = 4'h0;
        pixel_blue  = 4'h0;
        shade_s     = gray_r;
        if (game_over) begin
            if (in_banner_s && font_bit_s) begin
                shade_s = ~gray_r;
            end else begin
                shade_s = gray_r;
            end
            pixel_red   = shade_s;
            pixel_green = shade_s;
            pixel_blue  = shade_s;
        end else if (!in_grid_s) begin
            pixel_red   = 4'h0;
            pixel_green = 4'h0;
            pixel_blue  = 4'h0;
        end else if (snake_hit_s) begin
            pixel_red   = 4'h0;
            pixel_green = 4'hF;
            pixel_blue  = 4'h0;
        end else if (food_hit_s) begin
            pixel_red   = 4'hF;
            pixel_green = 4'h0;
            pixel_blue  = 4'h0;
        end else begin
            pixel_red   = 4'h0;
            pixel_green = 4'h0;
            pixel_blue  = 4'h0;
        end
    end

endmodule

// File: tb/tb_snake_renderer.sv
// Testbench for snake_renderer: directed and random stimulus, expected
// colours pushed to a scoreboard queue and popped by a separate monitor.

module tb_snake_renderer;

    localparam int GRID_W   = 100;
    localparam int GRID_H   = 75;
    localparam int MAX_LEN  = 64;
    localparam int POS_BITS = 13;
    localparam int X0       = (GRID_W - 72) / 2;
    localparam int Y0       = (GRID_H - 8) / 2;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        frame_tick;
    logic [10:0]                 XCoord;
    logic [10:0]                 YCoord;
    logic [POS_BITS*MAX_LEN-1:0] snake_body_flat;
    logic [6:0]                  snake_length;
    logic [POS_BITS-1:0]         food_pos;
    logic                        game_over;
    logic [3:0]                  pixel_red;
    logic [3:0]                  pixel_green;
    logic [3:0]                  pixel_blue;

    snake_renderer #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN), .POS_BITS(POS_BITS)
    ) dut (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
        .XCoord(XCoord), .YCoord(YCoord),
        .snake_body_flat(snake_body_flat), .snake_length(snake_length),
        .food_pos(food_pos), .game_over(game_over),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue)
    );

    always #5 clk = ~clk;

    // Reference state
    int          body_m [MAX_LEN];
    int          frames_in_go = 0;   // frame ticks seen since game over began
    string       msg = "GAME OVER";

    // Scoreboard
    logic [11:0] exp_q [$];
    string       name_q [$];
    event        sample_ev;
    int          n_total = 0;
    int          n_pass  = 0;

    // Number of frame ticks seen since the game-over screen started.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)           frames_in_go <= 0;
        else if (!game_over) frames_in_go <= 0;
        else if (frame_tick) frames_in_go <= frames_in_go + 1;
    end

    function automatic logic [63:0] font(input byte c);
        case (c)
            "G": return 64'h3C66606E66663C00;
            "A": return 64'h183C66667E666600;
            "M": return 64'h63777F6B63636300;
            "E": return 64'h7E60607C60607E00;
            "O": return 64'h3C66666666663C00;
            "V": return 64'h66666666663C1800;
            "R": return 64'h7C66667C6C666600;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [11:0] ref_color(input int x, input int y, input int len,
                                              input int food, input bit go, input int gray);
        int p, shade, bx, by;
        logic [63:0] f;
        bit hit;
        p = (y * GRID_W + x) % (1 << POS_BITS);
        if (go) begin
            shade = gray;
            bx = x - X0;
            by = y - Y0;
            if (bx >= 0 && bx < 72 && by >= 0 && by < 8) begin
                f = font(msg.getc(bx / 8));
                if (f[63 - (by * 8 + bx % 8)]) shade = 15 - gray;
            end
            return {shade[3:0], shade[3:0], shade[3:0]};
        end
        if (x >= GRID_W || y >= GRID_H) return 12'h000;
        hit = 1'b0;
        for (int i = 0; i < len; i++) if (body_m[i] == p) hit = 1'b1;
        if (hit) return 12'h0F0;
        if (p == food) return 12'hF00;
        return 12'h000;
    endfunction

    task automatic pack_body();
        for (int i = 0; i < MAX_LEN; i++)
            snake_body_flat[i*POS_BITS +: POS_BITS] = POS_BITS'(body_m[i]);
    endtask

    // Push the expected colour for the current inputs and wake the monitor.
    task automatic push_check(input string nm);
        #1;
        exp_q.push_back(ref_color(int'(XCoord), int'(YCoord), int'(snake_length),
                                  int'(food_pos), game_over, frames_in_go % 16));
        name_q.push_back(nm);
        -> sample_ev;
        #1;
    endtask

    task automatic probe(input int x, input int y, input string nm);
        @(negedge clk);
        XCoord = 11'(x);
        YCoord = 11'(y);
        push_check(nm);
    endtask

    task automatic tick_cycle();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Monitor: compare DUT colour against each queued expectation.
    initial begin : monitor
        logic [11:0] e, got;
        string n;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                got = {pixel_red, pixel_green, pixel_blue};
                n_total++;
                if (got === e) n_pass++;
                else $display("FAIL %s: got rgb=%h expected rgb=%h (x=%0d y=%0d go=%0b)",
                              n, got, e, XCoord, YCoord, game_over);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int x, y, p;
        rstn = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
        XCoord = 11'd0; YCoord = 11'd0;
        for (int i = 0; i < MAX_LEN; i++) body_m[i] = 8000;
        pack_body();
        snake_length = 7'd0; food_pos = 13'd8000;
        repeat (2) @(negedge clk);

        // Held in reset: outputs stay combinational
        snake_length = 7'd1; body_m[0] = 123; pack_body();
        probe(23, 1, "rst_snake");
        game_over = 1'b1;
        probe(17, 33, "rst_go_text");
        probe(14, 33, "rst_go_bg");
        @(negedge clk);
        game_over = 1'b0;
        rstn = 1'b1;

        // Normal play
        probe(23, 1, "snake_hit");
        snake_length = 7'd0; food_pos = 13'd250;
        probe(50, 2, "food_only");
        snake_length = 7'd1; body_m[0] = 250; pack_body();
        probe(50, 2, "snake_over_food");
        probe(1, 1, "empty_cell");
        probe(100, 0, "x_off_grid");
        probe(99, 75, "y_off_grid");
        probe(2047, 2047, "far_off_grid");

        // Game over, no ticks yet
        game_over = 1'b1;
        probe(14, 33, "go_bg0");
        probe(17, 33, "go_text0");
        probe(14, 34, "go_g_row1");

        repeat (3) tick_cycle();
        probe(14, 33, "gray3_bg");
        probe(17, 33, "gray3_text");
        repeat (13) tick_cycle();
        probe(14, 33, "wrap_bg");
        probe(17, 33, "wrap_text");

        // Snake and food under the game-over screen
        repeat (2) tick_cycle();
        body_m[0] = Y0 * GRID_W + X0; pack_body(); food_pos = 13'(Y0 * GRID_W + X0 + 1);
        probe(14, 33, "go_hides_snake");
        probe(15, 33, "go_hides_food");

        // One cycle without game over clears the level
        @(negedge clk); game_over = 1'b0;
        probe(14, 33, "snake_visible");
        game_over = 1'b1;
        probe(14, 33, "gray_cleared");

        // Tick coincident with game_over rising
        @(negedge clk); game_over = 1'b0;
        @(negedge clk); game_over = 1'b1; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        push_check("rise_tick");

        // Asynchronous reset during game over
        repeat (4) tick_cycle();
        probe(20, 35, "pre_reset");
        @(negedge clk); #2; rstn = 1'b0;
        push_check("async_reset");
        @(negedge clk); rstn = 1'b1;

        // Random stimulus
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) game_over = ~game_over;
            frame_tick = 1'($urandom_range(0, 1));
            if (game_over && $urandom_range(0, 1) == 1) begin
                x = X0 + $urandom_range(0, 71);
                y = Y0 + $urandom_range(0, 7);
            end else begin
                x = $urandom_range(0, 110);
                y = $urandom_range(0, 80);
            end
            p = y * GRID_W + x;
            snake_length = 7'($urandom_range(0, MAX_LEN));
            for (int i = 0; i < MAX_LEN; i++) body_m[i] = $urandom_range(0, 7499);
            if ($urandom_range(0, 9) < 4) body_m[$urandom_range(0, MAX_LEN - 1)] = p;
            pack_body();
            food_pos = ($urandom_range(0, 9) < 3) ? 13'(p) : 13'($urandom_range(0, 7499));
            XCoord = 11'(x);
            YCoord = 11'(y);
            push_check("random");
        end

        #5;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
